// File: rtl/alu_exec_seq.sv
// Sequential ALU: single-cycle logic/arith/compare ops and bit-serial shifts (N+1 cycles for count N>0).
// Valid/ready on both sides; result held in DONE until out_ready. Optional signed-overflow trap: ALU_OVF_TRAP_EN.
module alu_exec_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         alu_ctrl,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               ovf
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_ADDU = 4'b0011;
    localparam logic [3:0] OP_SUBU = 4'b0100;
    localparam logic [3:0] OP_SLTU = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SLLV = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_SRAV = 4'b1011;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_SRL  = 4'b1101;
    localparam logic [3:0] OP_SRLV = 4'b1110;
    localparam logic [3:0] OP_XOR  = 4'b1111;

    localparam logic [1:0] SH_L = 2'd0;
    localparam logic [1:0] SH_R = 2'd1;
    localparam logic [1:0] SH_A = 2'd2;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [1:0]         kind_q, kind_d;

    logic [WIDTH-1:0]   sum, diff, alu_res, sh_next;
    logic               is_shift, trap;
    logic [SHAMT_W-1:0] sh_cnt;
    logic [1:0]         sh_kind;

    assign sum  = op_a + op_b;
    assign diff = op_a - op_b;

    always_comb begin
        alu_res  = '0;
        is_shift = 1'b0;
        sh_cnt   = '0;
        sh_kind  = SH_L;
        case (alu_ctrl)
            OP_AND:          alu_res = op_a & op_b;
            OP_OR:           alu_res = op_a | op_b;
            OP_ADD, OP_ADDU: alu_res = sum;
            OP_SUB, OP_SUBU: alu_res = diff;
            OP_SLTU:         alu_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
            OP_SLT:          alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_NOR:          alu_res = ~(op_a | op_b);
            OP_XOR:          alu_res = op_a ^ op_b;
            OP_SLL:  begin is_shift = 1'b1; sh_kind = SH_L; sh_cnt = shamt;             end
            OP_SLLV: begin is_shift = 1'b1; sh_kind = SH_L; sh_cnt = op_a[SHAMT_W-1:0]; end
            OP_SRL:  begin is_shift = 1'b1; sh_kind = SH_R; sh_cnt = shamt;             end
            OP_SRLV: begin is_shift = 1'b1; sh_kind = SH_R; sh_cnt = op_a[SHAMT_W-1:0]; end
            OP_SRA:  begin is_shift = 1'b1; sh_kind = SH_A; sh_cnt = shamt;             end
            OP_SRAV: begin is_shift = 1'b1; sh_kind = SH_A; sh_cnt = op_a[SHAMT_W-1:0]; end
            default:         alu_res = '0;
        endcase
        // A zero-count shift is just a pass-through of the shifted operand.
        if (is_shift) begin
            alu_res = op_b;
        end
    end

`ifdef ALU_OVF_TRAP_EN
    logic add_ovf, sub_ovf;
    assign add_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1]  != op_a[WIDTH-1]);
    assign sub_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
    assign trap    = ((alu_ctrl == OP_ADD) && add_ovf) || ((alu_ctrl == OP_SUB) && sub_ovf);
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        sh_next = sh_q;
        case (kind_q)
            SH_L:    sh_next = {sh_q[WIDTH-2:0], 1'b0};
            SH_R:    sh_next = {1'b0, sh_q[WIDTH-1:1]};
            SH_A:    sh_next = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
            default: sh_next = sh_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        kind_d  = kind_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (is_shift && (sh_cnt != '0)) begin
                        sh_d    = op_b;
                        cnt_d   = sh_cnt;
                        kind_d  = sh_kind;
                        state_d = SHIFT;
                    end else begin
                        res_d   = trap ? '0 : alu_res;
                        ovf_d   = trap;
                        state_d = DONE;
                    end
                end
            end
            SHIFT: begin
                sh_d  = sh_next;
                cnt_d = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    res_d   = sh_next;
                    ovf_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        zero_d = (res_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            res_q   <= '0;
            zero_q  <= 1'b1;
            ovf_q   <= 1'b0;
            sh_q    <= '0;
            cnt_q   <= '0;
            kind_q  <= SH_L;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            kind_q  <= kind_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = res_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_alu_exec_seq.sv
// Bench for alu_exec_seq: transaction-level model plus directed vectors with literal expectations.
`timescale 1ns/1ps
module tb_alu_exec_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [3:0]  alu_ctrl = 4'h0;
    logic [31:0] op_a = 32'h0;
    logic [31:0] op_b = 32'h0;
    logic [4:0]  shamt = 5'h0;
    logic        in_ready, out_valid, zero, ovf;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Model state: request outstanding, cycles still to wait, expected outputs.
    bit          m_busy = 1'b0;
    int          m_wait = 0;
    logic [31:0] m_res = 32'h0;
    logic        m_ovf = 1'b0;

    always #5 clk = ~clk;

    alu_exec_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b), .shamt(shamt),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .ovf(ovf)
    );

    function automatic void model_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                     input logic [4:0] sh, output logic [31:0] r, output logic o,
                                     output int n);
`ifdef ALU_OVF_TRAP_EN
        longint s;
`endif
        r = 32'h0;
        o = 1'b0;
        n = 0;
        case (c)
            4'h0: r = a & b;
            4'h1: r = a | b;
            4'h2, 4'h3: r = a + b;
            4'h4, 4'h6: r = a - b;
            4'h5: r = (a < b) ? 32'd1 : 32'd0;
            4'h7: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'h8: begin r = b << sh;               n = int'(sh);     end
            4'h9: begin r = b << a[4:0];           n = int'(a[4:0]); end
            4'hA: begin r = $signed(b) >>> sh;     n = int'(sh);     end
            4'hB: begin r = $signed(b) >>> a[4:0]; n = int'(a[4:0]); end
            4'hC: r = ~(a | b);
            4'hD: begin r = b >> sh;               n = int'(sh);     end
            4'hE: begin r = b >> a[4:0];           n = int'(a[4:0]); end
            default: r = a ^ b;
        endcase
`ifdef ALU_OVF_TRAP_EN
        if (c == 4'h2 || c == 4'h6) begin
            s = (c == 4'h2) ? longint'($signed(a)) + longint'($signed(b))
                            : longint'($signed(a)) - longint'($signed(b));
            if (s > 64'sd2147483647 || s < -64'sd2147483648) begin
                o = 1'b1;
                r = 32'h0;
            end
        end
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Issue one request, measure latency, check literals against DUT and model, then drain.
    task automatic run_op(input string nm, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh, input logic [31:0] er, input logic eo, input int elat);
        int lat;
        in_valid = 1'b1; alu_ctrl = c; op_a = a; op_b = b; shamt = sh;
        @(posedge clk); #1;
        in_valid = 1'b0; alu_ctrl = ~c; op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678; shamt = ~sh;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, "_lat"}, 32'(lat), 32'(elat));
        chk({nm, "_result"}, result, er);
        chk({nm, "_zero"}, {31'b0, zero}, {31'b0, (er == 32'h0)});
        chk({nm, "_ovf"}, {31'b0, ovf}, {31'b0, eo});
        chk({nm, "_model"}, m_res, er);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        fork
            forever begin : model_proc
                logic [31:0] r;
                logic        o;
                int          n;
                @(posedge clk or negedge rst_n);
                if (!rst_n) begin
                    m_busy = 1'b0; m_wait = 0; m_res = 32'h0; m_ovf = 1'b0;
                end else if (!m_busy) begin
                    if (in_valid) begin
                        model_op(alu_ctrl, op_a, op_b, shamt, r, o, n);
                        m_res = r; m_ovf = o; m_wait = n; m_busy = 1'b1;
                    end
                end else if (m_wait > 0) begin
                    m_wait--;
                end else if (out_ready) begin
                    m_busy = 1'b0;
                end
            end
            forever begin : compare_proc
                logic exp_v;
                @(negedge clk);
                if (chk_en) begin
                    exp_v = m_busy && (m_wait == 0);
                    chk("cyc_out_valid", {31'b0, out_valid}, {31'b0, exp_v});
                    chk("cyc_in_ready", {31'b0, in_ready}, {31'b0, !m_busy});
                    if (exp_v && out_valid) begin
                        chk("cyc_result", result, m_res);
                        chk("cyc_zero", {31'b0, zero}, {31'b0, (m_res == 32'h0)});
                        chk("cyc_ovf", {31'b0, ovf}, {31'b0, m_ovf});
                    end
                end
            end
        join_none

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_result", result, 32'h0);
        chk("rst_zero", {31'b0, zero}, 32'd1);
        chk("rst_ovf", {31'b0, ovf}, 32'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); #1;

        run_op("add",   4'h2, 32'h0000_0005, 32'h0000_0003, 5'd0, 32'h0000_0008, 1'b0, 1);
        run_op("sub",   4'h6, 32'h1234_5678, 32'h1234_5678, 5'd0, 32'h0000_0000, 1'b0, 1);
        run_op("slt",   4'h7, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 32'h0000_0001, 1'b0, 1);
        run_op("sltu",  4'h5, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 32'h0000_0000, 1'b0, 1);
        run_op("sra",   4'hA, 32'h0000_0000, 32'h8000_0000, 5'd4, 32'hF800_0000, 1'b0, 5);
        run_op("srlv",  4'hE, 32'h0000_0004, 32'h8000_0000, 5'd0, 32'h0800_0000, 1'b0, 5);
        run_op("sll0",  4'h8, 32'h0000_0000, 32'hA5A5_A5A5, 5'd0, 32'hA5A5_A5A5, 1'b0, 1);
        run_op("sllv",  4'h9, 32'h0000_001F, 32'h0000_0001, 5'd0, 32'h8000_0000, 1'b0, 32);
        run_op("srl1",  4'hD, 32'h0000_0000, 32'h8000_0001, 5'd1, 32'h4000_0000, 1'b0, 2);
        run_op("srav0", 4'hB, 32'h0000_0020, 32'h8000_0001, 5'd9, 32'h8000_0001, 1'b0, 1);
        run_op("srav3", 4'hB, 32'h0000_0003, 32'h8000_0010, 5'd0, 32'hF000_0002, 1'b0, 4);
        run_op("nor",   4'hC, 32'h0F0F_0000, 32'h00F0_000F, 5'd0, 32'hF000_FFF0, 1'b0, 1);
        run_op("xor",   4'hF, 32'hA5A5_A5A5, 32'hFFFF_0000, 5'd0, 32'h5A5A_A5A5, 1'b0, 1);
        run_op("and",   4'h0, 32'hF0F0_F0F0, 32'h3C3C_3C3C, 5'd0, 32'h3030_3030, 1'b0, 1);
        run_op("or",    4'h1, 32'hF0F0_F0F0, 32'h3C3C_3C3C, 5'd0, 32'hFCFC_FCFC, 1'b0, 1);
        run_op("subu",  4'h4, 32'h0000_0000, 32'h0000_0001, 5'd0, 32'hFFFF_FFFF, 1'b0, 1);
        run_op("addu",  4'h3, 32'hFFFF_FFFF, 32'h0000_0002, 5'd0, 32'h0000_0001, 1'b0, 1);
        run_op("addu_v",4'h3, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 32'h8000_0000, 1'b0, 1);
`ifdef ALU_OVF_TRAP_EN
        run_op("add_ovf", 4'h2, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 32'h0000_0000, 1'b1, 1);
        run_op("sub_ovf", 4'h6, 32'h8000_0000, 32'h0000_0001, 5'd0, 32'h0000_0000, 1'b1, 1);
`else
        run_op("add_ovf", 4'h2, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 32'h8000_0000, 1'b0, 1);
        run_op("sub_ovf", 4'h6, 32'h8000_0000, 32'h0000_0001, 5'd0, 32'h7FFF_FFFF, 1'b0, 1);
`endif

        // Backpressure: hold the result 5 cycles while a competing request is offered.
        in_valid = 1'b1; alu_ctrl = 4'hF; op_a = 32'h0000_FFFF; op_b = 32'h0F0F_0F0F;
        @(posedge clk); #1;
        alu_ctrl = 4'h2; op_a = 32'h1; op_b = 32'h1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_result", result, 32'h0F0F_F0F0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release_valid", {31'b0, out_valid}, 32'd0);
        chk("bp_release_ready", {31'b0, in_ready}, 32'd1);

        // out_ready already high when out_valid rises: one-cycle transfer.
        out_ready = 1'b1;
        in_valid = 1'b1; alu_ctrl = 4'h1; op_a = 32'h0000_0100; op_b = 32'h0000_0001;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("sc_valid", {31'b0, out_valid}, 32'd1);
        chk("sc_result", result, 32'h0000_0101);
        @(posedge clk); #1;
        chk("sc_drop_valid", {31'b0, out_valid}, 32'd0);
        chk("sc_in_ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b0;

        // Reset in the middle of a long shift abandons it.
        in_valid = 1'b1; alu_ctrl = 4'h9; op_a = 32'h0000_001F; op_b = 32'h0000_0001;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("ms_busy_ready", {31'b0, in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("ms_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("ms_rst_ready", {31'b0, in_ready}, 32'd1);
        chk("ms_rst_result", result, 32'h0);
        chk("ms_rst_zero", {31'b0, zero}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (35) @(posedge clk);
        #1;
        chk("ms_no_output", {31'b0, out_valid}, 32'd0);
        run_op("post_rst", 4'h2, 32'h0000_0010, 32'h0000_0020, 5'd0, 32'h0000_0030, 1'b0, 1);

        repeat (2) @(posedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
